codeword_weight: RTL and testbench
==================================

CODEWORD_WEIGHT -- requirements
Module: codeword_weight

Interface
REQ-001 Parameter N, default 9800: codeword length in bits.
REQ-002 Parameter CHUNK, default 40: bits counted per cycle; N SHALL be an integer multiple of CHUNK (245 chunks at defaults).
REQ-003 Parameter WW, default 14: width of weight and threshold; 2^WW SHALL exceed N.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_b  input  1  reset, synchronous and active-high (asserted = 1 resets on the next rising clk edge).
REQ-006 cw_valid  input  1  one-cycle strobe from codegen valid: cw_din holds a complete codeword.
REQ-007 cw_din  input  [0:N-1]  codeword from codegen dout; bit 0 is first in index order.
REQ-008 wt_max  input  [WW-1:0]  acceptance threshold, sampled with cw_valid.
REQ-009 busy  output  1  high while a codeword is being scanned.
REQ-010 done  output  1  one-cycle pulse: weight and pass are final.
REQ-011 weight  output  [WW-1:0]  Hamming weight of the last accepted codeword.
REQ-012 pass  output  1  1 when weight <= sampled wt_max.

Function
REQ-013 FSM states SHALL be IDLE, SCAN and DONE; reset state is IDLE.
REQ-014 IDLE: cw_valid=1 accepts the codeword. The block captures cw_din into an internal N-bit register, captures wt_max, clears the accumulator and chunk counter, and goes to SCAN.
REQ-015 SCAN: each cycle, the block adds the popcount of the current CHUNK-bit slice to the accumulator. Chunk k covers cw_din[k*CHUNK : k*CHUNK+CHUNK-1], taken in ascending k.
REQ-016 Slice selection SHALL use a left shift of the captured register by CHUNK per cycle or an equivalent counter-indexed mux; there SHALL be no N-wide adder tree.
REQ-017 Chunk counter runs 0..N/CHUNK-1; after the last chunk is accumulated, FSM moves to DONE. The counter SHALL NOT wrap within a scan.
REQ-018 Latency: cw_valid accepted at cycle t.
  - Chunks are accumulated in cycles t+1..t+N/CHUNK.
  - done=1 in cycle t+N/CHUNK+1 (t+246 at defaults).
REQ-019 DONE lasts exactly one cycle with done=1, then returns to IDLE.
  - If cw_valid=1 in the DONE cycle, it SHALL be accepted exactly as in IDLE (back-to-back operation).
REQ-020 busy SHALL be 1 in SCAN and 0 in IDLE and DONE.
REQ-021 cw_valid while in SCAN SHALL be ignored with no effect on the scan in progress; no queuing.
REQ-022 weight and pass SHALL update only in the done cycle and hold until the next done.
  - They SHALL NOT show partial sums while busy=1.
REQ-023 pass compares the full WW-bit unsigned weight against the wt_max captured at acceptance.
  - Changes to wt_max during SCAN SHALL have no effect.
REQ-024 Accumulator is WW bits unsigned and SHALL never overflow, since N < 2^WW.
REQ-025 cw_din SHALL only be sampled in the accept cycle; it may change freely afterwards.

Reset
REQ-026 With rst_b=1 at a rising edge:
  - FSM goes to IDLE.
  - busy=0, done=0, weight=0, pass=0.
  - Accumulator, chunk counter and captured threshold cleared.
REQ-027 Reset during SCAN SHALL abort the scan; no done pulse follows for the aborted codeword.
REQ-028 cw_valid coincident with rst_b=1 SHALL be ignored.
REQ-029 The internal codeword register needs no reset value; it is fully overwritten on accept.

Verification
REQ-030 All-zero codeword, wt_max=0, cw_valid at t -> done=1 only at t+246; weight=0, pass=1; busy=1 exactly in t+1..t+245.
REQ-031 All-ones codeword, wt_max=9799 -> weight=9800, pass=0; then all-ones with wt_max=9800 -> weight=9800, pass=1.
REQ-032 Only bits 0, 39, 40 and 9799 set, wt_max=3 -> weight=4, pass=0 (checks chunk boundaries and the last chunk).
REQ-033 Second cw_valid (all-ones) pulsed at t+100 during a scan of all-zero -> ignored; done at t+246 with weight=0. Third cw_valid in the done cycle -> accepted; next done 246 cycles later with the new result.
REQ-034 Random codeword, wt_max toggled every cycle during SCAN -> pass uses the value sampled at acceptance; weight matches the reference popcount.
REQ-035 rst_b=1 at t+120 of a scan -> next cycle busy=0, weight=0, pass=0; no done for the aborted codeword; a fresh cw_valid afterwards completes normally.

Source files
------------

// File: rtl/codeword_weight.sv
// Hamming weight of an N-bit codeword, counted CHUNK bits per cycle, with a
// threshold test against the wt_max captured when the codeword is accepted.
module codeword_weight #(
    parameter int N     = 9800,
    parameter int CHUNK = 40,
    parameter int WW    = 14
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          cw_valid,
    input  logic [0:N-1]  cw_din,
    input  logic [WW-1:0] wt_max,
    output logic          busy,
    output logic          done,
    output logic [WW-1:0] weight,
    output logic          pass
);

    localparam int NUM_CHUNKS = N / CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           r_state;
    logic [0:N-1]     r_cw;
    logic [WW-1:0]    r_acc;
    logic [WW-1:0]    r_max;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [WW-1:0]    w_pop;
    logic [WW-1:0]    w_sum;

    function automatic logic [WW-1:0] popcount(input logic [0:CHUNK-1] v);
        logic [WW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + WW'(v[i]);
        end
        return c;
    endfunction

    // A new codeword is taken in IDLE and also in the DONE cycle (back-to-back).
    assign w_accept = cw_valid && (r_state != SCAN);
    assign w_pop    = popcount(r_cw[0:CHUNK-1]);
    assign w_sum    = r_acc + w_pop;

    // NOTE: the codeword register is deliberately left without reset; every
    // accept overwrites all N bits, so a reset branch would only add fan-out.
    always_ff @(posedge clk) begin
        if (!rst_b && w_accept) begin
            r_cw <= cw_din;
        end else if (r_state == SCAN) begin
            // Shifting toward index 0 keeps the current chunk at r_cw[0:CHUNK-1].
            r_cw <= r_cw << CHUNK;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            weight  <= '0;
            pass    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (cw_valid) begin
                        r_max   <= wt_max;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SCAN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SCAN: begin
                    r_acc <= w_sum;
                    if (r_cnt == LAST_CHUNK) begin
                        weight  <= w_sum;
                        pass    <= (w_sum <= r_max);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codeword_weight.sv
// Randomised self-checking bench for codeword_weight; expected weight comes
// from $countones on the whole codeword, latency from the chunk count.
module tb_codeword_weight;

    localparam int N     = 9800;
    localparam int CHUNK = 40;
    localparam int WW    = 14;
    localparam int LAT   = N / CHUNK + 1;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          cw_valid;
    logic [0:N-1]  cw_din;
    logic [WW-1:0] wt_max;
    logic          busy;
    logic          done;
    logic [WW-1:0] weight;
    logic          pass;

    int n_checks = 0;
    int n_errors = 0;

    // Reference of the last reported result (what weight/pass must hold).
    logic [WW-1:0] m_weight = '0;
    logic          m_pass   = 1'b0;

    codeword_weight #(.N(N), .CHUNK(CHUNK), .WW(WW)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .cw_valid (cw_valid),
        .cw_din   (cw_din),
        .wt_max   (wt_max),
        .busy     (busy),
        .done     (done),
        .weight   (weight),
        .pass     (pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [0:N-1] rand_cw();
        logic [0:N-1] v;
        for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Drive a codeword for one cycle; returns at the negedge of cycle t+1.
    task automatic accept(input logic [0:N-1] cw, input logic [WW-1:0] wm);
        cw_valid = 1'b1;
        cw_din   = cw;
        wt_max   = wm;
        @(negedge clk);
        cw_valid = 1'b0;
        cw_din   = rand_cw();
        wt_max   = WW'($urandom);
    endtask

    // Observe an accepted scan from cycle t+1 onwards.
    task automatic scan_and_check(input string tag, input logic [0:N-1] cw,
                                  input logic [WW-1:0] wm, input bit toggle,
                                  input int spur_at, input bit b2b,
                                  input logic [0:N-1] next_cw,
                                  input logic [WW-1:0] next_wm);
        logic [WW-1:0] exp_w;
        logic          exp_p;
        int done_at  = -1;
        int n_done   = 0;
        int busy_bad = 0;
        int hold_bad = 0;
        exp_w = WW'($countones(cw));
        exp_p = (int'(exp_w) <= int'(wm));
        for (int c = 1; c <= LAT + 4; c++) begin
            if (busy !== (c < LAT)) busy_bad++;
            if (c < LAT && (weight !== m_weight || pass !== m_pass)) hold_bad++;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (c == LAT) begin
                check({tag, "_weight"}, int'(weight), int'(exp_w));
                check({tag, "_pass"}, int'(pass), int'(exp_p));
                m_weight = exp_w;
                m_pass   = exp_p;
                if (b2b) begin
                    accept(next_cw, next_wm);
                    break;
                end
            end
            cw_valid = (c == spur_at);
            if (c == spur_at) cw_din = '1;
            if (toggle && c < LAT) wt_max = ~wt_max;
            @(negedge clk);
        end
        cw_valid = 1'b0;
        check({tag, "_done_cycle"}, done_at, LAT);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_hold"}, hold_bad, 0);
    endtask

    task automatic run(input string tag, input logic [0:N-1] cw,
                       input logic [WW-1:0] wm, input bit toggle);
        accept(cw, wm);
        scan_and_check(tag, cw, wm, toggle, -1, 1'b0, '0, '0);
    endtask

    initial begin
        logic [0:N-1] cw;
        logic [0:N-1] cw2;
        int           bad;
        int           n_done;

        // Reset with a coincident cw_valid that must be ignored.
        rst_b    = 1'b1;
        cw_valid = 1'b1;
        cw_din   = '1;
        wt_max   = '1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_weight", int'(weight), 0);
        check("rst_pass", int'(pass), 0);
        rst_b    = 1'b0;
        cw_valid = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("rst_valid_ignored", bad, 0);

        run("zero", '0, '0, 1'b0);
        run("ones_9799", '1, WW'(9799), 1'b0);
        run("ones_9800", '1, WW'(9800), 1'b0);

        cw = '0;
        cw[0] = 1'b1; cw[39] = 1'b1; cw[40] = 1'b1; cw[N-1] = 1'b1;
        run("bounds", cw, WW'(3), 1'b0);
        run("bounds_eq", cw, WW'(4), 1'b0);

        // Spurious valid mid-scan, then a back-to-back accept in the done cycle.
        cw2 = rand_cw();
        accept('0, '0);
        scan_and_check("spur", '0, '0, 1'b0, 100, 1'b1, cw2, WW'(N / 2));
        scan_and_check("b2b", cw2, WW'(N / 2), 1'b0, -1, 1'b0, '0, '0);

        // wt_max toggling during scan; threshold set right at the weight.
        for (int k = 0; k < 4; k++) begin
            cw = rand_cw();
            run("toggle", cw, WW'($countones(cw) - (k % 2)), 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            cw = rand_cw();
            run("random", cw, WW'($urandom_range(0, N)), 1'b0);
        end

        // Reset in the middle of a scan aborts it.
        cw = '1;
        accept(cw, '1);
        repeat (119) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_weight", int'(weight), 0);
        check("abort_pass", int'(pass), 0);
        m_weight = '0;
        m_pass   = 1'b0;
        n_done = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);
        cw = rand_cw();
        run("after_abort", cw, WW'($urandom_range(0, N)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
